// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - control/status bundle between a sequence-generator driver and seq_gen
interface seq_gen_if #(
    parameter int CW = 4
) ();
    logic          start;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gap;
    logic          stop;
    logic          dout;
    logic          busy;
    logic          done;
    logic [2:0]    state;
    logic [CW-1:0] frame_cnt;

    modport master (
        output start, cnt, gap, stop,
        input  dout, busy, done, state, frame_cnt
    );

    modport slave (
        input  start, cnt, gap, stop,
        output dout, busy, done, state, frame_cnt
    );
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - framed serial pattern generator, MSB first, with frame count, gap and graceful stop
module seq_gen #(
    parameter int              PLEN    = 6,
    parameter logic [PLEN-1:0] PATTERN = 6'b101011,
    parameter int              CW      = 4
) (
    input  logic   clk,
    input  logic   rst,
    seq_gen_if.slave sg
);
    localparam int IW = (PLEN > 1) ? $clog2(PLEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SEND = 3'b001,
        S_GAP  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [PLEN-1:0] pat_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] gap_q;
    logic [CW-1:0] gap_left_q;
    logic [CW-1:0] frame_cnt_q;
    logic          stop_pend_q;
    logic          dout_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] frame_cnt_d;
    logic          last_frame;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        last_frame  = ((cnt_q != '0) && (frame_cnt_d == cnt_q)) || stop_pend_q || sg.stop;
    end

    // dout_q always holds the bit for the cycle being entered; pat_q holds the bits still to go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pat_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            gap_left_q  <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dout_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (sg.start) begin
                        cnt_q       <= sg.cnt;
                        gap_q       <= sg.gap;
                        stop_pend_q <= 1'b0;
                        frame_cnt_q <= '0;
                        idx_q       <= '0;
                        pat_q       <= {PATTERN[PLEN-2:0], 1'b0};
                        dout_q      <= PATTERN[PLEN-1];
                        busy_q      <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sg.stop) stop_pend_q <= 1'b1;
                    if (idx_q == IW'(PLEN-1)) begin
                        frame_cnt_q <= frame_cnt_d;
                        if (last_frame) begin
                            state_q <= S_DONE;
                            dout_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (gap_q == '0) begin
                            idx_q  <= '0;
                            pat_q  <= {PATTERN[PLEN-2:0], 1'b0};
                            dout_q <= PATTERN[PLEN-1];
                        end else begin
                            state_q    <= S_GAP;
                            gap_left_q <= gap_q - 1'b1;
                            dout_q     <= 1'b0;
                        end
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        dout_q <= pat_q[PLEN-1];
                        pat_q  <= {pat_q[PLEN-2:0], 1'b0};
                    end
                end
                S_GAP: begin
                    if (sg.stop) begin
                        state_q <= S_DONE;
                        dout_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_left_q == '0) begin
                        state_q <= S_SEND;
                        idx_q   <= '0;
                        pat_q   <= {PATTERN[PLEN-2:0], 1'b0};
                        dout_q  <= PATTERN[PLEN-1];
                    end else begin
                        gap_left_q <= gap_left_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sg.dout      = dout_q;
    assign sg.busy      = busy_q;
    assign sg.done      = done_q;
    assign sg.state     = state_q;
    assign sg.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - directed-vector bench for seq_gen with a 101011 window detector model
module tb_seq_gen;
    logic clk = 1'b0;
    logic rst;

    seq_gen_if #(.CW(4)) sg ();

    seq_gen #(.PLEN(6), .PATTERN(6'b101011), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .sg  (sg)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] stream;
    logic [5:0]  win;
    int          hits;
    int          busy_cyc;
    int          done_cyc;
    int          done_at;
    int          cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        stream = '0; win = '0; hits = 0; busy_cyc = 0; done_cyc = 0; done_at = -1; cyc = 0;
    endtask

    task automatic step();
        stream = {stream[62:0], sg.dout};
        win    = {win[4:0], sg.dout};
        if (win == 6'b101011) hits++;
        if (sg.busy) busy_cyc++;
        if (sg.done) begin
            done_cyc++;
            if (done_at < 0) done_at = cyc;
        end
        cyc++;
        tick();
    endtask

    task automatic run_until_done(input int max_cyc);
        int n = 0;
        while (done_cyc == 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("done_seen", 64'(done_cyc), 64'd1);
    endtask

    task automatic go(input logic [3:0] c, input logic [3:0] g);
        sg.cnt   = c;
        sg.gap   = g;
        sg.start = 1'b1;
        tick();
        sg.start = 1'b0;
        clear_obs();
    endtask

    initial begin
        rst = 1'b1;
        sg.start = 1'b0; sg.stop = 1'b0; sg.cnt = '0; sg.gap = '0;
        clear_obs();
        #12;
        check("rst_dout", 64'(sg.dout), 64'd0);
        check("rst_busy", 64'(sg.busy), 64'd0);
        check("rst_done", 64'(sg.done), 64'd0);
        check("rst_state", 64'(sg.state), 64'd0);
        check("rst_fcnt", 64'(sg.frame_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // single frame
        go(4'd1, 4'd0);
        check("single_first_bit", 64'(sg.dout), 64'd1);
        check("single_busy_rise", 64'(sg.busy), 64'd1);
        run_until_done(20);
        check("single_stream", stream, 64'b1010110);
        check("single_done_at", 64'(done_at), 64'd6);
        check("single_busy_cyc", 64'(busy_cyc), 64'd6);
        check("single_det", 64'(hits), 64'd1);
        check("single_fcnt", 64'(sg.frame_cnt), 64'd1);
        check("single_idle", 64'(sg.state), 64'd0);
        check("single_done_low", 64'(sg.done), 64'd0);

        // three frames, gap 2
        go(4'd3, 4'd2);
        run_until_done(40);
        check("multi_stream", stream, 64'b10101100101011001010110);
        check("multi_busy_cyc", 64'(busy_cyc), 64'd22);
        check("multi_done_at", 64'(done_at), 64'd22);
        check("multi_det", 64'(hits), 64'd3);
        check("multi_fcnt", 64'(sg.frame_cnt), 64'd3);
        tick();
        check("multi_done_once", 64'(done_cyc), 64'd1);

        // continuous with stop at bit 3 of frame 5; start mid-run must be ignored
        go(4'd0, 4'd0);
        for (int c = 0; c < 34; c++) begin
            if (c == 10) begin sg.start = 1'b1; sg.cnt = 4'd2; sg.gap = 4'd3; end
            if (c == 11) sg.start = 1'b0;
            if (c == 27) sg.stop = 1'b1;
            if (c == 28) sg.stop = 1'b0;
            step();
        end
        check("cont_done_at", 64'(done_at), 64'd30);
        check("cont_busy_cyc", 64'(busy_cyc), 64'd30);
        check("cont_done_cnt", 64'(done_cyc), 64'd1);
        check("cont_det", 64'(hits), 64'd5);
        check("cont_fcnt", 64'(sg.frame_cnt), 64'd5);
        check("cont_idle", 64'(sg.state), 64'd0);

        // asynchronous reset during bit 2
        go(4'd1, 4'd0);
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("arst_dout", 64'(sg.dout), 64'd0);
        check("arst_state", 64'(sg.state), 64'd0);
        check("arst_busy", 64'(sg.busy), 64'd0);
        #2;
        rst = 1'b0;
        tick();
        go(4'd1, 4'd0);
        run_until_done(20);
        check("arst_restart_stream", stream, 64'b1010110);
        check("arst_restart_det", 64'(hits), 64'd1);

        // cnt=15, gap=15: no trailing gap before DONE
        go(4'd15, 4'd15);
        run_until_done(400);
        check("max_done_at", 64'(done_at), 64'd300);
        check("max_busy_cyc", 64'(busy_cyc), 64'd300);
        check("max_det", 64'(hits), 64'd15);
        check("max_fcnt", 64'(sg.frame_cnt), 64'd15);

        // continuous wrap of frame_cnt
        go(4'd0, 4'd0);
        repeat (90) step();
        check("wrap_fcnt15", 64'(sg.frame_cnt), 64'd15);
        repeat (6) step();
        check("wrap_fcnt0", 64'(sg.frame_cnt), 64'd0);
        check("wrap_state", 64'(sg.state), 64'd1);
        check("wrap_busy", 64'(sg.busy), 64'd1);
        repeat (6) step();
        check("wrap_fcnt1", 64'(sg.frame_cnt), 64'd1);
        sg.stop = 1'b1;
        step();
        sg.stop = 1'b0;
        run_until_done(20);
        check("wrap_done_at", 64'(done_at), 64'd108);
        check("wrap_det", 64'(hits), 64'd18);
        check("wrap_fcnt_end", 64'(sg.frame_cnt), 64'd2);

        // stop during gap
        go(4'd0, 4'd3);
        repeat (6) step();
        check("gapstop_in_gap", 64'(sg.state), 64'd2);
        check("gapstop_dout", 64'(sg.dout), 64'd0);
        sg.stop = 1'b1;
        step();
        sg.stop = 1'b0;
        check("gapstop_state", 64'(sg.state), 64'd4);
        check("gapstop_done", 64'(sg.done), 64'd1);
        check("gapstop_fcnt", 64'(sg.frame_cnt), 64'd1);
        step();
        check("gapstop_idle", 64'(sg.state), 64'd0);
        check("gapstop_dout_idle", 64'(sg.dout), 64'd0);

        // start and stop together in IDLE: start wins, stop not remembered
        sg.stop = 1'b1;
        go(4'd2, 4'd0);
        sg.stop = 1'b0;
        run_until_done(30);
        check("ss_fcnt", 64'(sg.frame_cnt), 64'd2);
        check("ss_det", 64'(hits), 64'd2);
        check("ss_done_at", 64'(done_at), 64'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator that transmits the framed 6-bit sequence 101011 (MSB first) on a single data line. It is the transmit end of the serial sequence-detection path: its `dout` drives the `din` of the sequence detector, which flags each complete 101011. Software or a bench sets a frame count and an inter-frame gap, then pulses `start`. The block reports progress on `busy`, `done`, `state` and `frame_cnt`.

## Interface

Parameters:
- `PATTERN`, default 6'b101011: transmitted bit pattern, sent MSB first.
- `PLEN`, default 6: pattern length in bits.
- `CW`, default 4: width of the count and gap fields.

Ports:
- `clk`  in  1  single clock. All state updates occur on the rising edge, so `dout` is stable when the detector samples on the falling edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request, sampled in IDLE only.
- `cnt`  in  CW  number of frames to send; 0 = continuous until `stop`. Latched on accepted `start`.
- `gap`  in  CW  number of idle 0 bits between frames. Latched on accepted `start`.
- `stop`  in  1  graceful stop request: finish the current frame, then end.
- `dout`  out  1  serial data.
- `busy`  out  1  high in SEND and GAP.
- `done`  out  1  one-cycle pulse in DONE.
- `state`  out  3  current FSM state.
- `frame_cnt`  out  CW  frames completed since last `start`; wraps modulo 2^CW.

## Operation

- States: IDLE=3'b000, SEND=3'b001, GAP=3'b010, DONE=3'b100. Unused encodings go to IDLE on the next edge.
- **IDLE:**
  - `dout`=0.
  - `start`=1 latches `cnt`, `gap` and `stop_pend`=0, clears `frame_cnt` and bit index, and enters SEND.
- **SEND:**
  - `dout` = PATTERN[PLEN-1-idx], where idx runs 0..PLEN-1, one bit per cycle.
  - On the edge after idx=PLEN-1, `frame_cnt` increments. The frame is last if (cnt≠0 and frame_cnt+1==cnt) or `stop_pend`=1 or `stop`=1 in that cycle.
  - Last frame → DONE.
  - Not last, latched gap=0 → stay in SEND with idx=0 (back-to-back frames).
  - Not last, gap>0 → GAP.
- **GAP:**
  - `dout`=0 for exactly `gap` cycles, then SEND with idx=0.
  - `stop` during GAP → DONE on the next edge. No further frame starts.
- **DONE:** `done`=1, `dout`=0, `busy`=0 for one cycle, then IDLE.
- **`stop`:**
  - Sampled in SEND sets the sticky `stop_pend`. The current frame always completes; a partial frame is never emitted.
  - Ignored in IDLE and DONE.
- **`start`:** ignored in SEND, GAP and DONE. Latched `cnt` and `gap` are unaffected by input changes mid-operation.
- **Reset:** async `rst`=1 forces IDLE immediately. Reset values: `dout`=0, `busy`=0, `done`=0, `state`=000, `frame_cnt`=0, idx=0, `stop_pend`=0. A frame truncated by reset is acceptable; the detector is reset alongside.

## Timing

- Latency:
  - `start` sampled at edge k → first bit (1) valid from edge k until edge k+1.
  - Frame bits occupy cycles k..k+PLEN-1.
- Single frame with cnt=1 and gap=0:
  - DONE in the cycle after edge k+6, so `done` is high for edge k+6 to k+7.
  - IDLE from edge k+7.
- Frame period is PLEN+gap cycles. Back-to-back frames (gap=0) have no idle bits.
- `frame_cnt` updates on the same edge that leaves the last bit.
- `busy` rises with the first bit and falls on entry to DONE.
- `start` and `stop` asserted together in IDLE: `start` wins and `stop` is ignored.
- Continuous mode, `frame_cnt` reaching 2^CW-1: wraps to 0 with no state change.

## Test plan

- Single frame (cnt=1, gap=0, pulse `start`):
  - `dout` over 6 cycles = 1,0,1,0,1,1, then 0.
  - `done`=1 exactly 1 cycle later; `frame_cnt`=1.
  - Detector `dout` pulses once.
- Multi-frame with gap (cnt=3, gap=2):
  - Stream = 101011 00 101011 00 101011.
  - `busy` high for 22 cycles, `done` once, `frame_cnt`=3.
  - Detector fires 3 times.
- Continuous with stop (cnt=0, gap=0), `stop` asserted at bit 3 of frame 5:
  - Frame 5 completes, then DONE; `frame_cnt`=5.
  - `start` pulsed while busy is ignored: no restart, latched values unchanged.
- Reset mid-frame (`rst` asserted asynchronously between edges during bit 2):
  - `dout`=0, `state`=000, `busy`=0 immediately, without waiting for a clock edge.
  - After `rst` deasserts, a new `start` sends a clean full frame.
- Edge values:
  - cnt=15, gap=15: last frame followed directly by DONE with no trailing gap.
  - Continuous mode run through 17 frames: `frame_cnt` wraps 15→0.
  - `stop` during GAP → DONE next edge; no extra frame.
